// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the restoring divider.
package div_pkg;

  localparam int DIV_N     = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational iteration of restoring division:
// shift {A,Qreg} left, trial-subtract the divisor, restore on a negative result.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] qreg,
  input  logic [N-1:0] mreg,
  output logic [N:0]   a_next,
  output logic [N-1:0] qreg_next
);

  logic [2*N:0] shifted;
  logic [N:0]   a_sh;
  logic [N:0]   diff;

  // The partial remainder never exceeds the divisor, so its top bit is always zero
  // before the shift and dropping it here loses nothing.
  always_comb begin
    shifted   = {a, qreg} << 1;
    a_sh      = shifted[2*N:N];
    diff      = a_sh - {1'b0, mreg};
    qreg_next = shifted[N-1:0];
    if (diff[N]) begin
      a_next       = a_sh;
      qreg_next[0] = 1'b0;
    end else begin
      a_next       = diff;
      qreg_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_32_bit.sv
// Free-running unsigned restoring divider: loads operands on the first edge after
// reset, produces one quotient bit per clock, then holds the result until reset.
module div_32_bit
  import div_pkg::*;
#(
  parameter int N     = DIV_N,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] Q,
  input  logic [N-1:0] M,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N:0]         a_q, a_d;
  logic [N-1:0]       qreg_q, qreg_d;
  logic [N-1:0]       mreg_q, mreg_d;
  logic [N-1:0]       quotient_q, quotient_d;
  logic [N-1:0]       remainder_q, remainder_d;

  logic [N:0]         step_a;
  logic [N-1:0]       step_q;

  div_step #(.N(N)) u_step (
    .a         (a_q),
    .qreg      (qreg_q),
    .mreg      (mreg_q),
    .a_next    (step_a),
    .qreg_next (step_q)
  );

  // resetn is active-high: 1 holds the divider cleared.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      a_q         <= '0;
      qreg_q      <= '0;
      mreg_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      qreg_q      <= qreg_d;
      mreg_q      <= mreg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    qreg_d      = qreg_q;
    mreg_d      = mreg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      LOAD: begin
        a_d     = '0;
        qreg_d  = Q;
        mreg_d  = M;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d    = step_a;
        qreg_d = step_q;
        cnt_d  = cnt_q + CNT_W'(1);
        // The final iteration writes its result straight to the output registers.
        if (cnt_q == CNT_W'(N - 1)) begin
          quotient_d  = step_q;
          remainder_d = step_a[N-1:0];
          state_d     = DONE;
        end
      end
      DONE: begin
      end
      default: state_d = LOAD;
    endcase
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_div_32_bit.sv
// Scoreboard bench for div_32_bit: expected results are queued when a division is
// launched and compared once the fixed 33-edge latency has elapsed.
module tb_div_32_bit;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] Q = '0;
  logic [31:0] M = '0;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int pass_cnt = 0;
  int fail_cnt = 0;

  typedef struct {
    logic [31:0] quo;
    logic [31:0] rem;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  div_32_bit dut (
    .clk       (clk),
    .resetn    (resetn),
    .Q         (Q),
    .M         (M),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] q, input logic [31:0] m);
    exp_t e;
    if (m == 32'd0) begin
      e.quo = 32'hFFFF_FFFF;
      e.rem = q;
    end else begin
      e.quo = q / m;
      e.rem = q % m;
    end
    return e;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] exp_q, input logic [31:0] exp_r);
    assert (quotient === exp_q) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("[TB] FAIL %s quotient: got %h expected %h", tag, quotient, exp_q);
    end
    assert (remainder === exp_r) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("[TB] FAIL %s remainder: got %h expected %h", tag, remainder, exp_r);
    end
  endtask

  // Hold reset for a cycle with the new operands, then release on a falling edge.
  task automatic apply_stimulus(input logic [31:0] q, input logic [31:0] m);
    @(negedge clk);
    resetn = 1'b1;
    Q = q;
    M = m;
    @(negedge clk);
    check_output("in_reset", 32'd0, 32'd0);
    resetn = 1'b0;
    sb.push_back(model(q, m));
  endtask

  task automatic run_division(input string tag, input bit check_all_idle);
    exp_t e;
    for (int edge_n = 1; edge_n <= 33; edge_n++) begin
      @(posedge clk);
      #1;
      if (edge_n < 33 && (check_all_idle || edge_n == 1 || edge_n == 32))
        check_output({tag, "_idle"}, 32'd0, 32'd0);
    end
    if (sb.size() == 0) begin
      fail_cnt++;
      $error("[TB] FAIL %s scoreboard: got empty queue expected one entry", tag);
    end else begin
      e = sb.pop_front();
      last_exp = e;
      check_output(tag, e.quo, e.rem);
    end
  endtask

  initial begin
    $display("[TB] start");

    apply_stimulus(32'd38, 32'd6);
    run_division("q38_m6", 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_output("q38_m6_hold", 32'd6, 32'd2);

    apply_stimulus(32'd100, 32'd25);
    run_division("q100_m25", 1'b0);

    apply_stimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_division("max_eq", 1'b0);

    apply_stimulus(32'h7FFF_FFFF, 32'd1);
    run_division("div_one", 1'b0);

    apply_stimulus(32'd1, 32'd50);
    run_division("small_q", 1'b0);

    apply_stimulus(32'hFFFF_FFFF, 32'h10);
    run_division("full_range", 1'b0);

    apply_stimulus(32'd123, 32'd0);
    run_division("div_zero", 1'b0);

    // Reset asserted between clock edges must clear held outputs at once.
    @(posedge clk);
    #2;
    resetn = 1'b1;
    #1;
    check_output("async_clear", 32'd0, 32'd0);

    // Abort a division partway through, then restart with new operands.
    apply_stimulus(32'd38, 32'd6);
    repeat (15) @(posedge clk);
    #2;
    resetn = 1'b1;
    #1;
    check_output("abort_clear", 32'd0, 32'd0);
    void'(sb.pop_front());
    @(negedge clk);
    Q = 32'd100;
    M = 32'd25;
    @(negedge clk);
    resetn = 1'b0;
    sb.push_back(model(32'd100, 32'd25));
    run_division("restart", 1'b0);

    @(negedge clk);
    Q = 32'd5;
    M = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    check_output("done_hold", last_exp.quo, last_exp.rem);
    check_output("done_hold_const", 32'd4, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
